cmd_cfg_param: RTL and testbench

Parametrised next-generation host command processor for the logic-analyzer core. It decodes 16-bit UART commands: register read, register write, and capture-RAM dump. It holds the trigger/config register file for NUM_CH channels and generates the RAM read address sequence for dumps. Unlike the previous generation, it owns the dump address counter, gates dumps on capture_done, NACKs unmapped addresses and channels, and presents packed multi-channel buses.

---
 rtl/cmd_cfg_param.sv | 275 +++++++++++++++++++++++++++
 tb/tb_cmd_cfg_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_cfg_param.sv
// Host command processor for the logic-analyzer core: decodes 16-bit UART commands,
// holds the trigger/config register file and sequences capture-RAM dumps.
module cmd_cfg_param #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9,
  parameter int NUM_CH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           i_cmd,
  input  logic                  i_cmd_rdy,
  input  logic                  i_resp_sent,
  input  logic                  i_set_capture_done,
  input  logic [NUM_CH*8-1:0]   i_rdata,
  input  logic [LOG2-1:0]       i_ram_addr,
  output logic [LOG2-1:0]       o_rd_addr,
  output logic [5:0]            o_trig_cfg,
  output logic [NUM_CH*5-1:0]   o_ch_trig_cfg,
  output logic [3:0]            o_decimator,
  output logic [7:0]            o_vih,
  output logic [7:0]            o_vil,
  output logic [15:0]           o_match,
  output logic [15:0]           o_mask,
  output logic [15:0]           o_baud_cnt,
  output logic [LOG2-1:0]       o_trig_pos,
  output logic [7:0]            o_resp,
  output logic                  o_send_resp,
  output logic                  o_clr_cmd_rdy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESP_WAIT = 3'd1,
    S_DMP_RD    = 3'd2,
    S_DMP_LOAD  = 3'd3,
    S_DMP_WAIT  = 3'd4
  } state_t;

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

  function automatic logic [LOG2-1:0] addr_inc(input logic [LOG2-1:0] a);
    addr_inc = (a == LAST_ADDR) ? {LOG2{1'b0}} : a + 1'b1;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [5:0]            r_trig_cfg, w_trig_cfg_nxt;
  logic [NUM_CH*5-1:0]   r_ch_trig_cfg, w_ch_trig_cfg_nxt;
  logic [3:0]            r_decimator, w_decimator_nxt;
  logic [7:0]            r_vih, w_vih_nxt, r_vil, w_vil_nxt;
  logic [15:0]           r_match, w_match_nxt, r_mask, w_mask_nxt, r_baud_cnt, w_baud_cnt_nxt;
  logic [LOG2-1:0]       r_trig_pos, w_trig_pos_nxt;
  logic [7:0]            r_resp, w_resp_nxt;
  logic [LOG2-1:0]       r_rd_addr, w_rd_addr_nxt;
  logic [LOG2-1:0]       r_cnt, w_cnt_nxt;
  logic [2:0]            r_dmp_ch, w_dmp_ch_nxt;
  logic                  r_send_resp, w_send_resp_nxt;
  logic                  r_clr_cmd_rdy, w_clr_cmd_rdy_nxt;

  logic [1:0]  w_op;
  logic [5:0]  w_addr;
  logic [2:0]  w_ch;
  logic [7:0]  w_wdata;
  logic [15:0] w_tp16;
  logic [7:0]  w_rd_data;
  logic        w_mapped;
  logic        w_dmp_ok;
  logic        w_do_wr;
  logic [5:0]  w_wr_sel;
  logic [7:0]  w_sel_byte;

  assign w_op     = i_cmd[15:14];
  assign w_addr   = i_cmd[13:8];
  assign w_ch     = i_cmd[10:8];
  assign w_wdata  = i_cmd[7:0];
  assign w_tp16   = 16'(r_trig_pos);
  assign w_dmp_ok = r_trig_cfg[5] & (w_ch != 3'd0) & ({1'b0, w_ch} <= 4'(NUM_CH));

  // Register read mux; reads are zero-extended to a byte
  always_comb begin
    w_rd_data = 8'h00;
    w_mapped  = 1'b1;
    case (w_addr)
      6'h00: w_rd_data = {2'b00, r_trig_cfg};
      6'h10: w_rd_data = {4'h0, r_decimator};
      6'h11: w_rd_data = r_vih;
      6'h12: w_rd_data = r_vil;
      6'h13: w_rd_data = r_match[15:8];
      6'h14: w_rd_data = r_match[7:0];
      6'h15: w_rd_data = r_mask[15:8];
      6'h16: w_rd_data = r_mask[7:0];
      6'h17: w_rd_data = r_baud_cnt[15:8];
      6'h18: w_rd_data = r_baud_cnt[7:0];
      6'h19: w_rd_data = w_tp16[15:8];
      6'h1A: w_rd_data = w_tp16[7:0];
      default: begin
        w_mapped = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
          w_rd_data = w_rd_data | ((w_addr == 6'(n + 1)) ? {3'b000, r_ch_trig_cfg[n*5 +: 5]} : 8'h00);
          w_mapped  = w_mapped | (w_addr == 6'(n + 1));
        end
      end
    endcase
  end

  // Channel byte selection for the dump in progress
  always_comb begin
    w_sel_byte = 8'h00;
    for (int n = 0; n < NUM_CH; n++) begin
      w_sel_byte = w_sel_byte | ((r_dmp_ch == 3'(n + 1)) ? i_rdata[n*8 +: 8] : 8'h00);
    end
  end

  // FSM next-state and response/dump-address sequencing
  always_comb begin
    w_state_nxt       = r_state;
    w_resp_nxt        = r_resp;
    w_send_resp_nxt   = 1'b0;
    w_clr_cmd_rdy_nxt = 1'b0;
    w_rd_addr_nxt     = r_rd_addr;
    w_cnt_nxt         = r_cnt;
    w_dmp_ch_nxt      = r_dmp_ch;
    w_do_wr           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_rdy) begin
          w_send_resp_nxt = 1'b1;
          w_state_nxt     = S_RESP_WAIT;
          case (w_op)
            2'b00: w_resp_nxt = w_mapped ? w_rd_data : 8'hEE;
            2'b01: begin
              w_resp_nxt = w_mapped ? 8'hA5 : 8'hEE;
              w_do_wr    = w_mapped;
            end
            2'b10: begin
              if (w_dmp_ok) begin
                w_send_resp_nxt = 1'b0;
                w_state_nxt     = S_DMP_RD;
                w_rd_addr_nxt   = addr_inc(i_ram_addr);
                w_cnt_nxt       = {LOG2{1'b0}};
                w_dmp_ch_nxt    = w_ch;
              end else begin
                w_resp_nxt = 8'hEE;
              end
            end
            default: w_resp_nxt = 8'hEE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RESP_WAIT: begin
        if (i_resp_sent) begin
          w_clr_cmd_rdy_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end else begin
          w_state_nxt = S_RESP_WAIT;
        end
      end
      S_DMP_RD: w_state_nxt = S_DMP_LOAD;
      S_DMP_LOAD: begin
        w_resp_nxt      = w_sel_byte;
        w_send_resp_nxt = 1'b1;
        w_state_nxt     = S_DMP_WAIT;
      end
      S_DMP_WAIT: begin
        if (i_resp_sent && (r_cnt == LAST_ADDR)) begin
          w_clr_cmd_rdy_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end else if (i_resp_sent) begin
          w_cnt_nxt     = r_cnt + 1'b1;
          w_rd_addr_nxt = addr_inc(r_rd_addr);
          w_state_nxt   = S_DMP_RD;
        end else begin
          w_state_nxt = S_DMP_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register file update; 0x3F is unmapped so it selects no field when no write commits
  assign w_wr_sel = w_do_wr ? w_addr : 6'h3F;

  always_comb begin
    w_trig_cfg_nxt    = r_trig_cfg | {i_set_capture_done, 5'b00000};
    w_ch_trig_cfg_nxt = r_ch_trig_cfg;
    w_decimator_nxt   = r_decimator;
    w_vih_nxt         = r_vih;
    w_vil_nxt         = r_vil;
    w_match_nxt       = r_match;
    w_mask_nxt        = r_mask;
    w_baud_cnt_nxt    = r_baud_cnt;
    w_trig_pos_nxt    = r_trig_pos;
    case (w_wr_sel)
      6'h00: w_trig_cfg_nxt  = w_wdata[5:0];
      6'h10: w_decimator_nxt = w_wdata[3:0];
      6'h11: w_vih_nxt       = w_wdata;
      6'h12: w_vil_nxt       = w_wdata;
      6'h13: w_match_nxt     = {w_wdata, r_match[7:0]};
      6'h14: w_match_nxt     = {r_match[15:8], w_wdata};
      6'h15: w_mask_nxt      = {w_wdata, r_mask[7:0]};
      6'h16: w_mask_nxt      = {r_mask[15:8], w_wdata};
      6'h17: w_baud_cnt_nxt  = {w_wdata, r_baud_cnt[7:0]};
      6'h18: w_baud_cnt_nxt  = {r_baud_cnt[15:8], w_wdata};
      6'h19: w_trig_pos_nxt  = LOG2'({w_wdata, w_tp16[7:0]});
      6'h1A: w_trig_pos_nxt  = LOG2'({w_tp16[15:8], w_wdata});
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          w_ch_trig_cfg_nxt[n*5 +: 5] = (w_wr_sel == 6'(n + 1)) ? w_wdata[4:0] : r_ch_trig_cfg[n*5 +: 5];
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_cfg    <= 6'h03;
      r_ch_trig_cfg <= {NUM_CH{5'h01}};
      r_decimator   <= 4'h0;
      r_vih         <= 8'hAA;
      r_vil         <= 8'h55;
      r_match       <= 16'h0000;
      r_mask        <= 16'h0000;
      r_baud_cnt    <= 16'h06C8;
      r_trig_pos    <= LOG2'(1);
      r_resp        <= 8'h00;
      r_rd_addr     <= {LOG2{1'b0}};
      r_cnt         <= {LOG2{1'b0}};
      r_dmp_ch      <= 3'd0;
      r_send_resp   <= 1'b0;
      r_clr_cmd_rdy <= 1'b0;
    end else begin
      r_trig_cfg    <= w_trig_cfg_nxt;
      r_ch_trig_cfg <= w_ch_trig_cfg_nxt;
      r_decimator   <= w_decimator_nxt;
      r_vih         <= w_vih_nxt;
      r_vil         <= w_vil_nxt;
      r_match       <= w_match_nxt;
      r_mask        <= w_mask_nxt;
      r_baud_cnt    <= w_baud_cnt_nxt;
      r_trig_pos    <= w_trig_pos_nxt;
      r_resp        <= w_resp_nxt;
      r_rd_addr     <= w_rd_addr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_dmp_ch      <= w_dmp_ch_nxt;
      r_send_resp   <= w_send_resp_nxt;
      r_clr_cmd_rdy <= w_clr_cmd_rdy_nxt;
    end
  end

  assign o_rd_addr     = r_rd_addr;
  assign o_trig_cfg    = r_trig_cfg;
  assign o_ch_trig_cfg = r_ch_trig_cfg;
  assign o_decimator   = r_decimator;
  assign o_vih         = r_vih;
  assign o_vil         = r_vil;
  assign o_match       = r_match;
  assign o_mask        = r_mask;
  assign o_baud_cnt    = r_baud_cnt;
  assign o_trig_pos    = r_trig_pos;
  assign o_resp        = r_resp;
  assign o_send_resp   = r_send_resp;
  assign o_clr_cmd_rdy = r_clr_cmd_rdy;

endmodule

// File: tb/tb_cmd_cfg_param.sv
// Self-checking bench for cmd_cfg_param: randomized commands and dumps against a
// byte-addressed register model and a simple capture-RAM model.
module tb_cmd_cfg_param;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
  localparam int NUM_CH  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic cmd_rdy = 1'b0, resp_sent = 1'b0, set_capture_done = 1'b0;
  logic [NUM_CH*8-1:0] rdata;
  logic [LOG2-1:0] ram_addr = '0;
  logic [LOG2-1:0] rd_addr, trig_pos;
  logic [5:0] trig_cfg;
  logic [NUM_CH*5-1:0] ch_trig_cfg;
  logic [3:0] decimator;
  logic [7:0] vih, vil, resp;
  logic [15:0] match, mask, baud_cnt;
  logic send_resp, clr_cmd_rdy;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mem [0:NUM_CH-1][0:ENTRIES-1];
  logic [7:0] m_reg [0:63];
  logic [7:0] m_wmask [0:63];
  bit         m_map [0:63];

  always #5 clk = ~clk;

  cmd_cfg_param #(.ENTRIES(ENTRIES), .LOG2(LOG2), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .i_cmd(cmd), .i_cmd_rdy(cmd_rdy), .i_resp_sent(resp_sent),
    .i_set_capture_done(set_capture_done), .i_rdata(rdata), .i_ram_addr(ram_addr),
    .o_rd_addr(rd_addr), .o_trig_cfg(trig_cfg), .o_ch_trig_cfg(ch_trig_cfg),
    .o_decimator(decimator), .o_vih(vih), .o_vil(vil), .o_match(match), .o_mask(mask),
    .o_baud_cnt(baud_cnt), .o_trig_pos(trig_pos), .o_resp(resp), .o_send_resp(send_resp),
    .o_clr_cmd_rdy(clr_cmd_rdy)
  );

  // synchronous capture RAM: data appears the cycle after the address
  always @(posedge clk) begin
    for (int n = 0; n < NUM_CH; n++) rdata[n*8 +: 8] <= mem[n][rd_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int a = 0; a < 64; a++) begin m_reg[a] = 8'h00; m_wmask[a] = 8'h00; m_map[a] = 1'b0; end
    m_map[0] = 1'b1; m_wmask[0] = 8'h3F; m_reg[0] = 8'h03;
    for (int n = 1; n <= NUM_CH; n++) begin m_map[n] = 1'b1; m_wmask[n] = 8'h1F; m_reg[n] = 8'h01; end
    for (int a = 16; a <= 26; a++) begin m_map[a] = 1'b1; m_wmask[a] = 8'hFF; end
    m_wmask[16] = 8'h0F;
    m_wmask[25] = 8'((1 << (LOG2 - 8)) - 1);
    m_reg[17] = 8'hAA; m_reg[18] = 8'h55; m_reg[23] = 8'h06; m_reg[24] = 8'hC8; m_reg[26] = 8'h01;
  endfunction

  function automatic logic [7:0] model_rd(input logic [5:0] a);
    return m_map[a] ? m_reg[a] : 8'hEE;
  endfunction

  // Drive one RD/WR/NACK transaction through the full handshake
  task automatic run_cmd(input logic [15:0] c, input bit scd, output logic [7:0] r,
                         output bit lat_ok, output bit hs_ok);
    int gap;
    cmd = c; cmd_rdy = 1'b1; set_capture_done = scd;
    @(posedge clk); #1;
    set_capture_done = 1'b0;
    lat_ok = (send_resp === 1'b1);
    r = resp;
    gap = $urandom_range(0, 3);
    @(posedge clk); #1;
    hs_ok = (send_resp === 1'b0) && (clr_cmd_rdy === 1'b0);
    repeat (gap) begin @(posedge clk); #1; end
    resp_sent = 1'b1;
    @(posedge clk); #1;
    resp_sent = 1'b0;
    hs_ok = hs_ok && (clr_cmd_rdy === 1'b1);
    cmd_rdy = 1'b0;
    @(posedge clk); #1;
    hs_ok = hs_ok && (clr_cmd_rdy === 1'b0);
  endtask

  task automatic pulse_capture_done();
    set_capture_done = 1'b1;
    @(posedge clk); #1;
    set_capture_done = 1'b0;
    m_reg[0] = m_reg[0] | 8'h20;
  endtask

  task automatic test_cfg_outputs(input string tag);
    logic [LOG2-1:0] exp_tp;
    exp_tp = LOG2'({m_reg[25], m_reg[26]});
    n_checks++;
    if (trig_cfg !== m_reg[0][5:0]) begin n_fail++; $display("FAIL %s trig_cfg got %h exp %h", tag, trig_cfg, m_reg[0][5:0]); end
    for (int n = 0; n < NUM_CH; n++) begin
      n_checks++;
      if (ch_trig_cfg[n*5 +: 5] !== m_reg[n+1][4:0]) begin
        n_fail++; $display("FAIL %s ch_trig_cfg[%0d] got %h exp %h", tag, n + 1, ch_trig_cfg[n*5 +: 5], m_reg[n+1][4:0]);
      end
    end
    n_checks++;
    if ({decimator, vih, vil} !== {m_reg[16][3:0], m_reg[17], m_reg[18]}) begin
      n_fail++; $display("FAIL %s dec/vih/vil got %h exp %h", tag, {decimator, vih, vil}, {m_reg[16][3:0], m_reg[17], m_reg[18]});
    end
    n_checks++;
    if ({match, mask, baud_cnt} !== {m_reg[19], m_reg[20], m_reg[21], m_reg[22], m_reg[23], m_reg[24]}) begin
      n_fail++; $display("FAIL %s match/mask/baud got %h", tag, {match, mask, baud_cnt});
    end
    n_checks++;
    if (trig_pos !== exp_tp) begin n_fail++; $display("FAIL %s trig_pos got %h exp %h", tag, trig_pos, exp_tp); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({resp, rd_addr, send_resp, clr_cmd_rdy} !== {8'h00, {LOG2{1'b0}}, 2'b00}) begin
      n_fail++; $display("FAIL reset_out got resp=%h rd_addr=%h send=%b clr=%b", resp, rd_addr, send_resp, clr_cmd_rdy);
    end
    test_cfg_outputs("reset");
  endtask

  task automatic test_read();
    logic [5:0] a;
    logic [7:0] r, e;
    bit lat, hs;
    for (int i = 0; i < 23; i++) begin
      case (i)
        0: begin a = 6'h17; e = 8'h06; end
        1: begin a = 6'h18; e = 8'hC8; end
        2: begin a = 6'h12; e = 8'h55; end
        default: begin a = 6'($urandom_range(0, 63)); e = model_rd(a); end
      endcase
      run_cmd({2'b00, a, 8'($urandom)}, 1'b0, r, lat, hs);
      n_checks++;
      if (r !== e || !lat || !hs) begin
        n_fail++; $display("FAIL rd_%02h resp %h exp %h latency_ok %0d handshake_ok %0d", a, r, e, lat, hs);
      end
    end
  endtask

  task automatic test_write();
    logic [5:0] a;
    logic [7:0] d, r, e;
    bit lat, hs;
    for (int i = 0; i < 28; i++) begin
      case (i)
        0: begin a = 6'h19; d = 8'hFF; end
        1: begin a = 6'h1A; d = 8'h34; end
        default: begin a = 6'($urandom_range(0, 31)); d = 8'($urandom); end
      endcase
      e = m_map[a] ? 8'hA5 : 8'hEE;
      run_cmd({2'b01, a, d}, 1'b0, r, lat, hs);
      if (m_map[a]) m_reg[a] = d & m_wmask[a];
      n_checks++;
      if (r !== e || !lat || !hs) begin
        n_fail++; $display("FAIL wr_%02h ack %h exp %h latency_ok %0d handshake_ok %0d", a, r, e, lat, hs);
      end
      if (i == 1) begin
        n_checks++;
        if (trig_pos !== LOG2'(12'h134)) begin n_fail++; $display("FAIL trig_pos_wr got %h exp 134", trig_pos); end
        run_cmd({2'b00, 6'h19, 8'h00}, 1'b0, r, lat, hs);
        n_checks++;
        if (r !== 8'h01) begin n_fail++; $display("FAIL rd_trig_pos_h got %h exp 01", r); end
      end
    end
    test_cfg_outputs("after_writes");
  endtask

  task automatic test_nack();
    logic [7:0] r;
    logic [15:0] c;
    bit lat, hs;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: c = {2'b00, 6'h07, 8'h00};
        1: c = {2'b01, 6'h3F, 8'($urandom)};
        2: c = {2'b01, 6'h1B, 8'($urandom)};
        default: c = {2'b11, 14'($urandom)};
      endcase
      run_cmd(c, 1'b0, r, lat, hs);
      n_checks++;
      if (r !== 8'hEE || !lat || !hs) begin
        n_fail++; $display("FAIL nack_%04h resp %h exp ee latency_ok %0d handshake_ok %0d", c, r, lat, hs);
      end
    end
    test_cfg_outputs("after_nack");
  endtask

  task automatic test_dump_gate();
    logic [7:0] r;
    bit lat, hs;
    run_cmd({2'b01, 6'h00, 8'h03}, 1'b0, r, lat, hs);
    m_reg[0] = 8'h03;
    run_cmd({2'b10, 3'b000, 3'd2, 8'h00}, 1'b0, r, lat, hs);
    n_checks++;
    if (r !== 8'hEE || !lat || !hs) begin n_fail++; $display("FAIL dmp_not_done resp %h exp ee", r); end
    pulse_capture_done();
    n_checks++;
    if (trig_cfg !== m_reg[0][5:0]) begin n_fail++; $display("FAIL capture_done trig_cfg %h exp %h", trig_cfg, m_reg[0][5:0]); end
    for (int ch = 6; ch <= 8; ch++) begin
      run_cmd({2'b10, 3'b000, 3'(ch), 8'h00}, 1'b0, r, lat, hs);
      n_checks++;
      if (r !== 8'hEE || !lat || !hs) begin n_fail++; $display("FAIL dmp_ch%0d resp %h exp ee", ch % 8, r); end
    end
    run_cmd({2'b01, 6'h00, 8'h07}, 1'b1, r, lat, hs);
    m_reg[0] = 8'h07;
    n_checks++;
    if (trig_cfg !== 6'h07 || r !== 8'hA5) begin n_fail++; $display("FAIL wr_vs_capture_done trig_cfg %h exp 07", trig_cfg); end
  endtask

  task automatic test_dump(input int ra, input int ch, input int abort_at);
    logic [LOG2-1:0] exp_addr;
    bit got;
    for (int n = 0; n < NUM_CH; n++)
      for (int a = 0; a < ENTRIES; a++) mem[n][a] = 8'($urandom);
    pulse_capture_done();
    ram_addr = LOG2'(ra);
    cmd = {2'b10, 3'b000, 3'(ch), 8'($urandom)};
    cmd_rdy = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(posedge clk); #1;
        got = (send_resp === 1'b1);
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL dump_ch%0d byte %0d no send_resp within 8 cycles", ch, i); cmd_rdy = 1'b0; return; end
      exp_addr = LOG2'((ra + 1 + i) % ENTRIES);
      n_checks++;
      if (rd_addr !== exp_addr || resp !== mem[ch-1][exp_addr]) begin
        n_fail++; $display("FAIL dump_ch%0d byte %0d addr %h exp %h resp %h exp %h", ch, i, rd_addr, exp_addr, resp, mem[ch-1][exp_addr]);
      end
      if (i == abort_at) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({rd_addr, resp, send_resp, clr_cmd_rdy} !== {{LOG2{1'b0}}, 8'h00, 2'b00}) begin
          n_fail++; $display("FAIL mid_dump_reset rd_addr %h resp %h send %b clr %b", rd_addr, resp, send_resp, clr_cmd_rdy);
        end
        test_cfg_outputs("mid_dump_reset");
        resp_sent = 1'b1;
        repeat (2) @(posedge clk);
        #1 resp_sent = 1'b0; cmd_rdy = 1'b0; rst_n = 1'b1;
        repeat (2) begin
          @(posedge clk); #1;
          n_checks++;
          if (clr_cmd_rdy !== 1'b0 || send_resp !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_pulses clr %b send %b exp 0 0", clr_cmd_rdy, send_resp);
          end
        end
        return;
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      resp_sent = 1'b1;
      @(posedge clk); #1;
      if (i % 37 == 5) begin @(posedge clk); #1; end
      resp_sent = 1'b0;
      n_checks++;
      if (clr_cmd_rdy !== (i == ENTRIES - 1)) begin
        n_fail++; $display("FAIL dump_ch%0d clr after byte %0d got %b", ch, i, clr_cmd_rdy);
      end
    end
    cmd_rdy = 1'b0;
    @(posedge clk); #1;
    test_cfg_outputs("after_dump");
  endtask

  task automatic test_after_reset_cmd();
    logic [7:0] r;
    bit lat, hs;
    run_cmd({2'b00, 6'h11, 8'h00}, 1'b0, r, lat, hs);
    n_checks++;
    if (r !== 8'hAA || !lat || !hs) begin n_fail++; $display("FAIL post_reset_rd resp %h exp aa latency_ok %0d", r, lat); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_nack();
    test_dump_gate();
    test_dump(ENTRIES - 1, 3, -1);
    test_dump(10, 1, -1);
    test_dump(123, 5, 5);
    test_after_reset_cmd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
